fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the simplified RISC-V core. Sits directly upstream of decode/control.
- Owns the PC register and issues requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small in-order FIFO and presents them to decode.
- Consumes pc_src and jump/branch targets to redirect the PC, flushing wrong-path instructions.

Parameters:
WIDTH, 32, address and PC width in bits
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, instruction FIFO entries; also the maximum (FIFO occupancy + outstanding requests)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  WIDTH  fetch address, word aligned
imem_rsp_valid  input  1  instruction word returned; in order, at least 1 cycle after acceptance
imem_rsp_data  input  32  instruction word
id_valid  output  1  FIFO head valid for decode
id_ready  input  1  decode/execute consumes head this cycle
id_instr  output  32  head instruction; opcode/funct3/funct7 are taken from here
id_pc  output  WIDTH  PC of head instruction
id_pc_plus4  output  WIDTH  id_pc + 4
pc_src  input  2  00 sequential, 01 branch/jump target, 10 JALR target, 11 treated as 00
branch_target  input  WIDTH  target when pc_src=01
jalr_target  input  WIDTH  target when pc_src=10

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc <= RESET_PC.
  - FIFO emptied; outstanding <= 0; drop_cnt <= 0.
  - imem_req_valid=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=4.
  - First request may assert in the first cycle with rst=0.
- Reset mid-operation: all state is cleared. Memory is reset on the same rst, so no stale response arrives. Any imem_rsp_valid with outstanding=0 is ignored.
- Consume: occurs when id_valid && id_ready. pc_src/targets are sampled only on a consume cycle and ignored otherwise.
- Redirect: a consume with pc_src in {01,10}. In the same edge:
  - fetch_pc <= target with bits [1:0] forced to 0.
  - FIFO flushed.
  - drop_cnt <= outstanding (after counting this cycle's accept/response).
- Request issue:
  - imem_req_valid = !rst && !redirect_this_cycle && credit>0 && !pending, where credit = DEPTH - fifo_count - outstanding + (consume ? 1 : 0).
  - A pending request (valid && !ready) holds imem_req_addr stable and stays valid, even across a redirect. Its response is then dropped via drop_cnt.
  - On accept: outstanding +1; fetch_pc <= fetch_pc + 4 (wraps modulo 2^WIDTH).
- Response:
  - outstanding -1.
  - If drop_cnt>0, decrement drop_cnt and discard the word.
  - Otherwise push {data, pc} into the FIFO. The PC is tracked by a separate rsp_pc register, advanced +4 per kept response and loaded with the target on redirect.
- Simultaneous events:
  - Accept and response in the same cycle leave outstanding unchanged.
  - Push and pop in the same cycle are allowed, including at full.
  - A response arriving on a redirect cycle counts as dropped. The flush wins; the word is never pushed.
- FIFO never overflows by construction of credit. A response arriving with FIFO full and no pop is an assertion failure.
- Outputs id_* come directly from the FIFO head register (no combinational path from imem_rsp_data). Minimum latency from request accept to id_valid is 2 cycles with 1-cycle memory.
- Throughput: 1 instruction/cycle sustained with 1-cycle memory and id_ready=1.

Test Plan:
- Reset release, imem always ready, 1-cycle latency, id_ready=1 -> addresses 0,4,8,… requested back-to-back; id_pc 0,4,8 on consecutive cycles; id_pc_plus4 = id_pc+4.
- id_ready=0 for 5 cycles -> at most DEPTH=2 instructions buffered plus in flight; imem_req_valid drops to 0; no loss/duplication after id_ready returns.
- Consume at id_pc=8 with pc_src=01, branch_target=0x40 -> next requests 0x40,0x44; in-flight words for 0xC/0x10 discarded; next id_pc=0x40.
- pc_src=10, jalr_target=0x103 -> request address 0x100, id_pc 0x100.
- imem_req_ready=0 for 3 cycles during a redirect to 0x80 -> old address held until accepted, its response dropped, then 0x80 fetched.
- rst asserted with 2 requests outstanding -> next cycle id_valid=0, imem_req_valid=0; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory and decode.
// The fetch unit takes the master view; memory, decode and the PC-select logic take the slave view.
interface fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_instr;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_pc_plus4;
  logic [1:0]       pc_src;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jalr_target;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
           pc_src, branch_target, jalr_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
           pc_src, branch_target, jalr_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited memory requests,
// buffers returned words in an in-order FIFO and flushes wrong-path work on redirect.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 2);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    SRC_SEQ     = 2'b00,
    SRC_BRANCH  = 2'b01,
    SRC_JALR    = 2'b10,
    SRC_SEQ_ALT = 2'b11
  } pc_src_e;

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] rsp_pc;
  logic [WIDTH-1:0] pend_addr;
  logic             pending;
  logic             stale;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      fifo_instr [DEPTH];
  logic [WIDTH-1:0] fifo_pc    [DEPTH];

  pc_src_e          src;
  logic             consume;
  logic             redirect;
  logic [WIDTH-1:0] target_raw;
  logic [WIDTH-1:0] target;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W:0]   credit_limit;
  logic             req_valid;
  logic [WIDTH-1:0] req_addr;
  logic             accept;
  logic             hold_after;
  logic             rsp_fire;
  logic             push;
  logic [CNT_W-1:0] out_next;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign src        = pc_src_e'(bus.pc_src);
  assign consume    = (count != '0) && bus.id_ready;
  assign redirect   = consume && ((src == SRC_BRANCH) || (src == SRC_JALR));
  assign target_raw = (src == SRC_JALR) ? bus.jalr_target : bus.branch_target;
  assign target     = {target_raw[WIDTH-1:2], 2'b00};

  // A slot frees up in the same cycle the head is consumed, which keeps 1 instr/cycle flowing.
  assign occupancy    = {1'b0, count} + {1'b0, outstanding};
  assign credit_limit = {1'b0, DEPTH_C} + {{CNT_W{1'b0}}, consume};

  // A request already presented must stay up with its address frozen, even across a redirect.
  assign req_valid  = !rst && (pending || (!redirect && (occupancy < credit_limit)));
  assign req_addr   = pending ? pend_addr : fetch_pc;
  assign accept     = req_valid && bus.imem_req_ready;
  assign hold_after = req_valid && !bus.imem_req_ready;

  assign rsp_fire = bus.imem_rsp_valid && (outstanding != '0);
  assign push     = rsp_fire && (drop_cnt == '0) && !redirect;
  assign out_next = outstanding + CNT_W'(accept) - CNT_W'(rsp_fire);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_addr;
  assign bus.id_valid       = (count != '0);
  assign bus.id_instr       = (count != '0) ? fifo_instr[rd_ptr] : 32'h0;
  assign bus.id_pc          = (count != '0) ? fifo_pc[rd_ptr] : '0;
  assign bus.id_pc_plus4    = bus.id_pc + WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      pend_addr   <= '0;
      pending     <= 1'b0;
      stale       <= 1'b0;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      pending     <= hold_after;
      outstanding <= out_next;
      if (hold_after)
        pend_addr <= req_addr;

      // A stale request was issued on the old path; once accepted it must not advance fetch_pc.
      if (accept)
        stale <= 1'b0;
      else if (redirect && hold_after)
        stale <= 1'b1;

      if (redirect) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        drop_cnt <= out_next + CNT_W'(hold_after);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept && !stale)
          fetch_pc <= fetch_pc + WIDTH'(4);
        if (rsp_fire && (drop_cnt != '0))
          drop_cnt <= drop_cnt - 1'b1;
        if (push) begin
          fifo_instr[wr_ptr] <= bus.imem_rsp_data;
          fifo_pc[wr_ptr]    <= rsp_pc;
          wr_ptr             <= next_ptr(wr_ptr);
          rsp_pc             <= rsp_pc + WIDTH'(4);
        end
        if (consume)
          rd_ptr <= next_ptr(rd_ptr);
        count <= count + CNT_W'(push) - CNT_W'(consume);
      end
    end
  end

  // Credit accounting guarantees room for every kept response.
  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(push && (count == DEPTH_C) && !consume));
  end

endmodule
